// File: rtl/usb_data_tx.sv
// USB low/full-speed DATA-packet serializer: SYNC, DATA0/DATA1 PID, payload, complemented CRC16,
// with zero-bit stuffing after six consecutive ones and per-endpoint data toggles.
module usb_data_tx #(
    parameter int MAX_PKT  = 8,
    parameter int LEN_W    = 4,
    parameter int NUM_EP   = 4,
    parameter int EP_W     = 2,
    parameter int EOP_BITS = 3
) (
    input  logic             useClk,
    input  logic             rst,
    input  logic             checkData,
    input  logic             start,
    input  logic [EP_W-1:0]  startEp,
    input  logic [LEN_W-1:0] byteCount,
    input  logic [7:0]       dataIn,
    output logic             dataReq,
    input  logic             ack,
    input  logic [EP_W-1:0]  ackEp,
    input  logic             toggleClear,
    input  logic [EP_W-1:0]  toggleClearEp,
    output logic             txBit,
    output logic             txOE,
    output logic             eopReq,
    output logic             busy
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SYNC,
        S_PID,
        S_DATA,
        S_CRC,
        S_EOP
    } state_t;

    localparam logic [7:0]       SYNC_PAT  = 8'h80;
    localparam logic [7:0]       PID_DATA0 = 8'hC3;
    localparam logic [7:0]       PID_DATA1 = 8'h4B;
    localparam logic [LEN_W-1:0] MAX_LEN   = LEN_W'(MAX_PKT);
    localparam logic [3:0]       EOP_LAST  = 4'(EOP_BITS - 1);

    state_t           state_q;
    logic [15:0]      shift_q;
    logic [3:0]       bits_left_q;
    logic [LEN_W-1:0] bytes_left_q;
    logic [7:0]       first_byte_q;
    logic             pid_q;
    logic [15:0]      crc_q;
    logic [15:0]      crc_d;
    logic [2:0]       ones_q;
    logic             eop_done_q;
    logic [3:0]       eop_cnt_q;
    logic [NUM_EP-1:0] toggle_q;
    logic [NUM_EP-1:0] toggle_d;
    logic [LEN_W-1:0] len_clamped;
    logic             tx_bit_q, tx_oe_q, data_req_q, eop_req_q, busy_q;

    assign txBit   = tx_bit_q;
    assign txOE    = tx_oe_q;
    assign dataReq = data_req_q;
    assign eopReq  = eop_req_q;
    assign busy    = busy_q;

    // NOTE: every signal assigned in always_comb gets a default first, so no path can infer a latch.
    always_comb begin
        len_clamped = (byteCount > MAX_LEN) ? MAX_LEN : byteCount;
        crc_d       = crc_q >> 1;
        if (shift_q[0] ^ crc_q[0]) begin
            crc_d = crc_d ^ 16'hA001;
        end
    end

    // Clear is applied after the flip so it wins when both hit the same endpoint.
    always_comb begin
        toggle_d = toggle_q;
        if (ack && (int'(ackEp) < NUM_EP)) begin
            toggle_d[ackEp] = ~toggle_q[ackEp];
        end
        if (toggleClear && (int'(toggleClearEp) < NUM_EP)) begin
            toggle_d[toggleClearEp] = 1'b0;
        end
    end

    always_ff @(posedge useClk) begin
        if (rst) begin
            toggle_q <= '0;
        end else begin
            toggle_q <= toggle_d;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge useClk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            shift_q      <= '0;
            bits_left_q  <= '0;
            bytes_left_q <= '0;
            first_byte_q <= '0;
            pid_q        <= 1'b0;
            crc_q        <= 16'hFFFF;
            ones_q       <= '0;
            eop_done_q   <= 1'b0;
            eop_cnt_q    <= '0;
            tx_bit_q     <= 1'b0;
            tx_oe_q      <= 1'b0;
            data_req_q   <= 1'b0;
            eop_req_q    <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            data_req_q <= 1'b0;
            eop_req_q  <= 1'b0;
            if (state_q == S_IDLE) begin
                if (start) begin
                    state_q      <= S_SYNC;
                    shift_q      <= {8'h00, SYNC_PAT};
                    bits_left_q  <= 4'd7;
                    bytes_left_q <= len_clamped;
                    pid_q        <= toggle_q[startEp];
                    crc_q        <= 16'hFFFF;
                    ones_q       <= '0;
                    eop_done_q   <= 1'b0;
                    eop_cnt_q    <= '0;
                    tx_oe_q      <= 1'b1;
                    busy_q       <= 1'b1;
                    if (len_clamped != '0) begin
                        first_byte_q <= dataIn;
                        data_req_q   <= 1'b1;
                    end
                end
            end else if (checkData) begin
                if ((ones_q == 3'd6) && !eop_done_q) begin
                    // Stuff slot: everything except the line holds for one bit time.
                    tx_bit_q <= 1'b0;
                    ones_q   <= '0;
                end else if (state_q == S_EOP) begin
                    if (!eop_done_q) begin
                        eop_req_q  <= 1'b1;
                        tx_bit_q   <= 1'b0;
                        eop_done_q <= 1'b1;
                    end else if (eop_cnt_q == EOP_LAST) begin
                        tx_oe_q <= 1'b0;
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end else begin
                        eop_cnt_q <= eop_cnt_q + 4'd1;
                    end
                end else begin
                    tx_bit_q    <= shift_q[0];
                    ones_q      <= shift_q[0] ? ones_q + 3'd1 : 3'd0;
                    shift_q     <= shift_q >> 1;
                    bits_left_q <= bits_left_q - 4'd1;
                    if (state_q == S_DATA) begin
                        crc_q <= crc_d;
                    end
                    if (bits_left_q == 4'd0) begin
                        case (state_q)
                            S_SYNC: begin
                                state_q     <= S_PID;
                                shift_q     <= {8'h00, (pid_q ? PID_DATA1 : PID_DATA0)};
                                bits_left_q <= 4'd7;
                            end
                            S_PID: begin
                                if (bytes_left_q == '0) begin
                                    state_q     <= S_CRC;
                                    shift_q     <= ~crc_q;
                                    bits_left_q <= 4'd15;
                                end else begin
                                    state_q      <= S_DATA;
                                    shift_q      <= {8'h00, first_byte_q};
                                    bits_left_q  <= 4'd7;
                                    bytes_left_q <= bytes_left_q - LEN_W'(1);
                                end
                            end
                            S_DATA: begin
                                if (bytes_left_q == '0) begin
                                    state_q     <= S_CRC;
                                    shift_q     <= ~crc_d;
                                    bits_left_q <= 4'd15;
                                end else begin
                                    shift_q      <= {8'h00, dataIn};
                                    data_req_q   <= 1'b1;
                                    bits_left_q  <= 4'd7;
                                    bytes_left_q <= bytes_left_q - LEN_W'(1);
                                end
                            end
                            S_CRC: begin
                                state_q <= S_EOP;
                            end
                            default: begin
                                state_q <= S_IDLE;
                            end
                        endcase
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_usb_data_tx.sv
// Self-checking bench for usb_data_tx: random payloads and bit-enable spacing compared against
// a bit-list model (SYNC, PID, payload, ~CRC16, then a separate bit-stuffing pass).
module tb_usb_data_tx;

    localparam int MAX_PKT  = 8;
    localparam int LEN_W    = 4;
    localparam int NUM_EP   = 4;
    localparam int EP_W     = 2;
    localparam int EOP_BITS = 3;
    localparam int BUDGET   = 3000;

    logic             useClk = 1'b0;
    logic             rst;
    logic             checkData;
    logic             start;
    logic [EP_W-1:0]  startEp;
    logic [LEN_W-1:0] byteCount;
    logic [7:0]       dataIn;
    logic             dataReq;
    logic             ack;
    logic [EP_W-1:0]  ackEp;
    logic             toggleClear;
    logic [EP_W-1:0]  toggleClearEp;
    logic             txBit;
    logic             txOE;
    logic             eopReq;
    logic             busy;

    int   n_checks = 0;
    int   n_errors = 0;
    bit   model_tog[NUM_EP];
    logic [7:0] payload[16];
    bit   exp_bits[$];
    bit   obs_bits[$];

    usb_data_tx #(
        .MAX_PKT(MAX_PKT), .LEN_W(LEN_W), .NUM_EP(NUM_EP), .EP_W(EP_W), .EOP_BITS(EOP_BITS)
    ) dut (
        .useClk(useClk), .rst(rst), .checkData(checkData), .start(start), .startEp(startEp),
        .byteCount(byteCount), .dataIn(dataIn), .dataReq(dataReq), .ack(ack), .ackEp(ackEp),
        .toggleClear(toggleClear), .toggleClearEp(toggleClearEp), .txBit(txBit), .txOE(txOE),
        .eopReq(eopReq), .busy(busy)
    );

    always #5 useClk = ~useClk;

    // Bit-time enable with random spacing, changed away from the active edge.
    initial begin
        checkData = 1'b0;
        forever begin
            @(negedge useClk);
            checkData = ($urandom_range(0, 2) == 0);
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic build_expected(input bit pid, input int len);
        bit          raw[$];
        logic [15:0] crc;
        logic [7:0]  pid_byte;
        bit          b, fb;
        int          run;
        raw = {};
        crc = 16'hFFFF;
        for (int i = 0; i < 7; i++) raw.push_back(1'b0);
        raw.push_back(1'b1);
        pid_byte = pid ? 8'h4B : 8'hC3;
        for (int i = 0; i < 8; i++) raw.push_back(pid_byte[i]);
        for (int k = 0; k < len; k++) begin
            for (int i = 0; i < 8; i++) begin
                b  = payload[k][i];
                raw.push_back(b);
                fb = b ^ crc[0];
                crc = crc >> 1;
                if (fb) crc = crc ^ 16'hA001;
            end
        end
        for (int i = 0; i < 16; i++) raw.push_back(~crc[i]);
        exp_bits = {};
        run = 0;
        foreach (raw[i]) begin
            exp_bits.push_back(raw[i]);
            run = raw[i] ? run + 1 : 0;
            if (run == 6) begin
                exp_bits.push_back(1'b0);
                run = 0;
            end
        end
    endtask

    task automatic pulse_toggles(input bit do_ack, input int a_ep, input bit do_clr, input int c_ep);
        ack           = do_ack;
        ackEp         = EP_W'(a_ep);
        toggleClear   = do_clr;
        toggleClearEp = EP_W'(c_ep);
        @(negedge useClk);
        ack         = 1'b0;
        toggleClear = 1'b0;
        if (do_ack) model_tog[a_ep] = !model_tog[a_ep];
        if (do_clr) model_tog[c_ep] = 1'b0;
    endtask

    // Called and returns at a negedge. inj_kind: 0 none, 1 start while busy, 2 ack on ep, 3 reset.
    task automatic run_packet(input int ep, input int count, input int inj_kind, input int inj_en);
        int len, n_en, further, req_cnt, eop_cnt, idx, hold_viol, busy_viol, eop_off_cd, n_cmp;
        bit pid, eop_seen, was_cd, done, injected, prev_bit;
        len = (count > MAX_PKT) ? MAX_PKT : count;
        pid = model_tog[ep];
        build_expected(pid, len);
        obs_bits = {};
        {n_en, further, req_cnt, eop_cnt, hold_viol, busy_viol, eop_off_cd} = '0;
        {eop_seen, done, injected} = '0;
        idx       = 0;
        start     = 1'b1;
        startEp   = EP_W'(ep);
        byteCount = LEN_W'(count);
        dataIn    = payload[0];
        prev_bit  = txBit;
        for (int cyc = 0; cyc < BUDGET; cyc++) begin
            @(posedge useClk);
            was_cd = checkData && (cyc > 0);
            @(negedge useClk);
            start = 1'b0;
            ack   = 1'b0;
            if (rst) begin
                check("rst_txoe", txOE, 0);
                check("rst_busy", busy, 0);
                check("rst_eopreq", eopReq, 0);
                check("rst_datareq", dataReq, 0);
                check("rst_txbit", txBit, 0);
                rst = 1'b0;
                foreach (model_tog[i]) model_tog[i] = 1'b0;
                return;
            end
            if (cyc == 0) begin
                check("busy_after_start", busy, 1);
                check("oe_after_start", txOE, 1);
            end
            if (dataReq) begin
                req_cnt++;
                idx++;
                dataIn = (idx < 16) ? payload[idx] : 8'($urandom);
            end
            if (!was_cd && (txBit !== prev_bit)) hold_viol++;
            prev_bit = txBit;
            if (eopReq) begin
                eop_cnt++;
                if (!was_cd) eop_off_cd++;
            end
            if (was_cd) begin
                n_en++;
                if (eop_seen) begin
                    further++;
                end else if (eopReq) begin
                    eop_seen = 1'b1;
                    check("eop_position", n_en, exp_bits.size() + 1);
                    check("eop_txbit", txBit, 0);
                end else begin
                    obs_bits.push_back(txBit);
                end
            end
            if (busy !== txOE) busy_viol++;
            if ((cyc > 0) && !txOE) begin
                done = 1'b1;
                break;
            end
            if (!injected && (inj_kind != 0) && (n_en == inj_en)) begin
                injected = 1'b1;
                case (inj_kind)
                    1: begin
                        start     = 1'b1;
                        startEp   = EP_W'($urandom_range(0, NUM_EP - 1));
                        byteCount = LEN_W'($urandom_range(0, 15));
                    end
                    2: begin
                        ack   = 1'b1;
                        ackEp = EP_W'(ep);
                        model_tog[ep] = !model_tog[ep];
                    end
                    default: rst = 1'b1;
                endcase
            end
        end
        check("finished", done, 1);
        check("bit_count", obs_bits.size(), exp_bits.size());
        n_cmp = (obs_bits.size() < exp_bits.size()) ? obs_bits.size() : exp_bits.size();
        for (int i = 0; i < n_cmp; i++) check($sformatf("bit%0d", i), obs_bits[i], exp_bits[i]);
        check("datareq_count", req_cnt, len);
        check("eop_pulses", eop_cnt, 1);
        check("eop_on_enable", eop_off_cd, 0);
        check("eop_tail_enables", further, EOP_BITS);
        check("tx_hold", hold_viol, 0);
        check("busy_eq_oe", busy_viol, 0);
        check("busy_low_at_end", busy, 0);
        check("txbit_low_at_end", txBit, 0);
    endtask

    task automatic randomize_payload();
        foreach (payload[i]) payload[i] = 8'($urandom);
    endtask

    initial begin
        int quiet_viol;
        rst = 1'b1;
        {start, ack, toggleClear} = '0;
        startEp = '0; byteCount = '0; dataIn = '0; ackEp = '0; toggleClearEp = '0;
        foreach (model_tog[i]) model_tog[i] = 1'b0;
        repeat (3) @(negedge useClk);
        check("reset_txbit", txBit, 0);
        check("reset_txoe", txOE, 0);
        check("reset_datareq", dataReq, 0);
        check("reset_eopreq", eopReq, 0);
        check("reset_busy", busy, 0);
        rst = 1'b0;
        @(negedge useClk);

        // ZLP on EP0, then ACK flips to DATA1, then a retry keeps DATA1.
        randomize_payload();
        run_packet(0, 0, 0, 0);
        pulse_toggles(1'b1, 0, 1'b0, 0);
        run_packet(0, 0, 0, 0);
        run_packet(0, 0, 0, 0);

        // All-ones payload forces stuffing.
        payload[0] = 8'hFF;
        payload[1] = 8'hFF;
        run_packet(1, 2, 0, 0);

        // Length above MAX_PKT is clamped.
        randomize_payload();
        run_packet(1, 15, 0, 0);

        // EP2 at DATA1, then same-cycle ack+clear must leave DATA0; stray start mid-packet.
        if (!model_tog[2]) pulse_toggles(1'b1, 2, 1'b0, 0);
        pulse_toggles(1'b1, 2, 1'b1, 2);
        randomize_payload();
        run_packet(2, 3, 1, 3);

        // ACK during busy must not alter the latched PID but affects the next packet.
        randomize_payload();
        run_packet(3, 1, 2, 5);
        run_packet(3, 0, 0, 0);

        for (int n = 0; n < 10; n++) begin
            if ($urandom_range(0, 1) == 1)
                pulse_toggles(1'($urandom_range(0, 1)), $urandom_range(0, 3),
                              1'($urandom_range(0, 3) == 0), $urandom_range(0, 3));
            randomize_payload();
            run_packet($urandom_range(0, 3), $urandom_range(0, 15), 0, 0);
        end

        // Reset in the middle of DATA with non-zero toggles.
        if (!model_tog[1]) pulse_toggles(1'b1, 1, 1'b0, 0);
        if (!model_tog[3]) pulse_toggles(1'b1, 3, 1'b0, 0);
        randomize_payload();
        run_packet(1, 4, 3, 20);
        quiet_viol = 0;
        repeat (20) begin
            @(negedge useClk);
            if (eopReq || busy || txOE) quiet_viol++;
        end
        check("quiet_after_reset", quiet_viol, 0);
        randomize_payload();
        run_packet(1, 2, 0, 0);
        run_packet(3, 0, 0, 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/usb_data_tx.md
# usb_data_tx

Parametrised USB low-speed/full-speed DATA-packet serializer. It generalises the fixed descriptor transmitter to arbitrary payloads from a byte source, sized up to `MAX_PKT` bytes. It keeps a DATA0/DATA1 toggle per endpoint, updated by host ACKs. It performs true bit-stuffing by inserting a zero bit, and appends the complemented CRC16. Its serial output feeds the NRZI encoder/line driver, and its EOP request goes to the EOP generator.

## Interface
- `MAX_PKT`, 8: maximum payload bytes.
- `LEN_W`, 4: width of `byteCount`; must satisfy 2^LEN_W > MAX_PKT.
- `NUM_EP`, 4: number of endpoints with independent data toggles.
- `EP_W`, 2: endpoint index width, ≥ clog2(NUM_EP).
- `EOP_BITS`, 3: bit times `txOE` stays high after `eopReq`.
- `useClk` in 1: single clock, all logic on rising edge.
- `rst` in 1: synchronous, active-high reset.
- `checkData` in 1: bit-time enable, one `useClk` pulse per bit period.
- `start` in 1: request transmission of one packet.
- `startEp` in EP_W: endpoint for `start`.
- `byteCount` in LEN_W: payload length; 0 = zero-length packet (ZLP).
- `dataIn` in 8: current payload byte, sent LSB first.
- `dataReq` out 1: one-cycle pulse when `dataIn` is sampled.
- `ack` in 1 / `ackEp` in EP_W: host ACK received; flip toggle of `ackEp`.
- `toggleClear` in 1 / `toggleClearEp` in EP_W: force that endpoint to DATA0.
- `txBit` out 1: serial bit, pre-NRZI.
- `txOE` out 1: line drive enable.
- `eopReq` out 1: one-cycle pulse requesting EOP.
- `busy` out 1: high from accepted `start` until `txOE` falls.

## Operation
- **Reset values:** `txBit`=0, `txOE`=0, `dataReq`=0, `eopReq`=0, `busy`=0, all toggles DATA0, state IDLE.
- **States:** IDLE → SYNC → PID → DATA → CRC → EOP → IDLE.
- **State advance:** the FSM, shifters, CRC and stuff counter advance only on `checkData` cycles. Exceptions: `start` acceptance, `ack`/`toggleClear` updates and `dataReq` can occur on any cycle.
- **IDLE:**
  - `start` is accepted when `busy`=0.
  - On acceptance, latch length as min(`byteCount`, MAX_PKT), latch PID from the toggle of `startEp`, and clear the CRC to 16'hFFFF.
  - Set `busy` and `txOE`.
  - `start` while `busy`=1 is ignored.
- **SYNC:** sends 8'h80 LSB first, i.e. seven 0s then a 1.
- **PID:** sends 8'hC3 (DATA0) or 8'h4B (DATA1), LSB first.
- **DATA:**
  - At each byte load point, `dataIn` is sampled and `dataReq` pulses in the same cycle.
  - The source must present the next byte within 8 bit times.
  - The first byte must already be valid when `start` is accepted.
  - A ZLP skips DATA.
- **CRC update:** for each DATA bit b: fb = b ^ crc[0]; crc = crc >> 1; if fb, crc ^= 16'hA001.
- **CRC:** transmits ~crc, LSB first, 16 bits.
- **Bit stuffing:**
  - The ones-counter starts at the last SYNC bit and counts consecutive 1s on `txBit`.
  - After six 1s, a 0 is inserted in the next bit slot. Shifters, CRC and state are held for that slot, and the counter resets.
  - Stuffing applies through the final CRC bit, including a stuff bit after a trailing sixth 1.
- **EOP:**
  - On the `checkData` after the last bit (including any stuff bit), `eopReq` pulses and `txBit`=0.
  - After EOP_BITS further enables, `txOE`=0 and `busy`=0.
- **Toggles:**
  - `ack` flips `toggle[ackEp]`.
  - `toggleClear` clears `toggle[toggleClearEp]`.
  - If both target the same endpoint in the same cycle, clear wins.
  - Updates during `busy` do not change the PID already latched.
  - No `ack` means the next `start` on that endpoint resends the same PID (retry).
- **Reset mid-packet:** all outputs return to reset values on the next cycle; no `eopReq`.

## Timing
- The first SYNC bit appears on the first `checkData` strictly after the `start` cycle.
- Each `txBit` value changes only on `checkData` cycles and is held between them.
- Bit count per packet = 32 + 8·len + stuffed bits.
- `busy` is high from the `start`+1 cycle until the cycle `txOE` falls.
- A new `start` is accepted in the cycle after `busy` falls.

## Test plan
- **ZLP on EP0 after reset**, `start` with `byteCount`=0 → `txBit` sequence 00000001, 11000011, then sixteen 0s; `eopReq` at bit 33; no `dataReq`.
- **Toggle and retry:** ZLP on EP0, `ack` with `ackEp`=0, ZLP on EP0 → PID bits 11010010 (4B). A third `start` without `ack` → PID bits 11010010 again.
- **Stuffing:** 2-byte packet 8'hFF, 8'hFF → a 0 is inserted after every six consecutive 1s. Total bits = 32+16+stuff count. `dataReq` pulses exactly twice. CRC matches the software model.
- **Clamp:** `byteCount`=15 with MAX_PKT=8 → exactly 8 `dataReq` pulses and 8 payload bytes.
- **Toggle conflict:** `ack` and `toggleClear` on EP2 in the same cycle, with EP2 at DATA1 → EP2 becomes DATA0 (next PID C3). Also, `start` during `busy` is ignored.
- **Reset mid-packet:** `rst` asserted in DATA → next cycle `txOE`=0, `busy`=0, no `eopReq`. All toggles become DATA0, and the next packet is sent correctly.
